// File: rtl/mmio_axi_master_pkg.sv
// Shared definitions for the MMIO-to-AXI4 initiator.
// Holds the fixed AXI field encodings used on every single-beat transfer
// and the state encoding of the request sequencer.
package mmio_axi_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_A    = 3'd1,
    ST_RD_D    = 3'd2,
    ST_WR_AW_W = 3'd3,
    ST_WR_B    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/mmio_axi_master.sv
// mmio_axi_master: turns one core MMIO load/store into one single-beat AXI4
// transaction (AR/R for loads, AW/W/B for stores) and reports rdata/err back.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   io_req_*                    core request (valid/ready, we, addr, wdata, wstrb)
//   io_resp_*                   one-cycle completion pulse with rdata and err
//   io_axi_ar_* / io_axi_r_*    AXI read address / read data channels
//   io_axi_aw_* / io_axi_w_*    AXI write address / write data channels
//   io_axi_b_*                  AXI write response channel
// All handshake outputs are registered, so no valid depends on a ready
// combinationally.
module mmio_axi_master
  import mmio_axi_master_pkg::*;
#(
  parameter logic [7:0] AXI_ID = 8'h00,
  parameter int         ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_we,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [31:0]       io_req_wdata,
  input  logic [3:0]        io_req_wstrb,
  output logic              io_resp_valid,
  output logic [31:0]       io_resp_rdata,
  output logic              io_resp_err,
  output logic [7:0]        io_axi_ar_id,
  output logic [ADDR_W-1:0] io_axi_ar_addr,
  output logic [7:0]        io_axi_ar_len,
  output logic [2:0]        io_axi_ar_size,
  output logic [1:0]        io_axi_ar_burst,
  output logic              io_axi_ar_valid,
  input  logic              io_axi_ar_ready,
  input  logic [7:0]        io_axi_r_id,
  input  logic [1:0]        io_axi_r_resp,
  input  logic [31:0]       io_axi_r_data,
  input  logic              io_axi_r_last,
  input  logic              io_axi_r_valid,
  output logic              io_axi_r_ready,
  output logic [7:0]        io_axi_aw_id,
  output logic [ADDR_W-1:0] io_axi_aw_addr,
  output logic [7:0]        io_axi_aw_len,
  output logic [2:0]        io_axi_aw_size,
  output logic [1:0]        io_axi_aw_burst,
  output logic              io_axi_aw_valid,
  input  logic              io_axi_aw_ready,
  output logic [31:0]       io_axi_w_data,
  output logic [3:0]        io_axi_w_strb,
  output logic              io_axi_w_last,
  output logic              io_axi_w_valid,
  input  logic              io_axi_w_ready,
  input  logic [7:0]        io_axi_b_id,
  input  logic [1:0]        io_axi_b_resp,
  input  logic              io_axi_b_valid,
  output logic              io_axi_b_ready
);

  state_e state_r;
  logic   aw_done_r;
  logic   w_done_r;

  logic   aw_hs_s;
  logic   w_hs_s;
  logic   aw_fin_s;
  logic   w_fin_s;
  logic   rd_err_s;
  logic   wr_err_s;

  // Fixed single-beat transfer attributes.
  assign io_axi_ar_id    = AXI_ID;
  assign io_axi_ar_len   = AXI_LEN_SINGLE;
  assign io_axi_ar_size  = AXI_SIZE_4B;
  assign io_axi_ar_burst = AXI_BURST_INCR;
  assign io_axi_aw_id    = AXI_ID;
  assign io_axi_aw_len   = AXI_LEN_SINGLE;
  assign io_axi_aw_size  = AXI_SIZE_4B;
  assign io_axi_aw_burst = AXI_BURST_INCR;
  assign io_axi_w_last   = 1'b1;

  // A channel counts as finished if it completed earlier or completes this cycle,
  // which lets AW and W finish in either order or together.
  assign aw_hs_s  = io_axi_aw_valid & io_axi_aw_ready;
  assign w_hs_s   = io_axi_w_valid & io_axi_w_ready;
  assign aw_fin_s = aw_done_r | aw_hs_s;
  assign w_fin_s  = w_done_r | w_hs_s;

  // A short or foreign-ID read beat is treated as an error as well as a non-OKAY response.
  assign rd_err_s = (io_axi_r_resp != AXI_RESP_OKAY) | (io_axi_r_id != AXI_ID) | ~io_axi_r_last;
  assign wr_err_s = (io_axi_b_resp != AXI_RESP_OKAY) | (io_axi_b_id != AXI_ID);

  // Request sequencer with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      aw_done_r       <= 1'b0;
      w_done_r        <= 1'b0;
      io_req_ready    <= 1'b1;
      io_resp_valid   <= 1'b0;
      io_resp_rdata   <= 32'h0000_0000;
      io_resp_err     <= 1'b0;
      io_axi_ar_addr  <= {ADDR_W{1'b0}};
      io_axi_ar_valid <= 1'b0;
      io_axi_r_ready  <= 1'b0;
      io_axi_aw_addr  <= {ADDR_W{1'b0}};
      io_axi_aw_valid <= 1'b0;
      io_axi_w_data   <= 32'h0000_0000;
      io_axi_w_strb   <= 4'b0000;
      io_axi_w_valid  <= 1'b0;
      io_axi_b_ready  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (io_req_valid) begin
            io_req_ready <= 1'b0;
            if (io_req_we) begin
              io_axi_aw_addr  <= io_req_addr;
              io_axi_w_data   <= io_req_wdata;
              io_axi_w_strb   <= io_req_wstrb;
              io_axi_aw_valid <= 1'b1;
              io_axi_w_valid  <= 1'b1;
              aw_done_r       <= 1'b0;
              w_done_r        <= 1'b0;
              state_r         <= ST_WR_AW_W;
            end else begin
              io_axi_ar_addr  <= io_req_addr;
              io_axi_ar_valid <= 1'b1;
              state_r         <= ST_RD_A;
            end
          end
        end
        ST_RD_A: begin
          if (io_axi_ar_ready) begin
            io_axi_ar_valid <= 1'b0;
            io_axi_r_ready  <= 1'b1;
            state_r         <= ST_RD_D;
          end
        end
        ST_RD_D: begin
          if (io_axi_r_valid) begin
            io_axi_r_ready <= 1'b0;
            io_resp_rdata  <= io_axi_r_data;
            io_resp_err    <= rd_err_s;
            io_resp_valid  <= 1'b1;
            state_r        <= ST_DONE;
          end
        end
        ST_WR_AW_W: begin
          if (aw_hs_s) begin
            io_axi_aw_valid <= 1'b0;
            aw_done_r       <= 1'b1;
          end
          if (w_hs_s) begin
            io_axi_w_valid <= 1'b0;
            w_done_r       <= 1'b1;
          end
          if (aw_fin_s && w_fin_s) begin
            io_axi_b_ready <= 1'b1;
            state_r        <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (io_axi_b_valid) begin
            io_axi_b_ready <= 1'b0;
            io_resp_rdata  <= 32'h0000_0000;
            io_resp_err    <= wr_err_s;
            io_resp_valid  <= 1'b1;
            state_r        <= ST_DONE;
          end
        end
        ST_DONE: begin
          io_resp_valid <= 1'b0;
          io_req_ready  <= 1'b1;
          state_r       <= ST_IDLE;
        end
        default: begin
          io_resp_valid   <= 1'b0;
          io_axi_ar_valid <= 1'b0;
          io_axi_r_ready  <= 1'b0;
          io_axi_aw_valid <= 1'b0;
          io_axi_w_valid  <= 1'b0;
          io_axi_b_ready  <= 1'b0;
          io_req_ready    <= 1'b1;
          state_r         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_axi_master.sv
// Directed self-checking bench for mmio_axi_master: the bench plays the core
// and the AXI responder, counts channel handshakes and compares against
// hand-computed expectations.
module tb_mmio_axi_master;

  logic        clk;
  logic        rst_n;
  logic        io_req_valid;
  logic        io_req_ready;
  logic        io_req_we;
  logic [31:0] io_req_addr;
  logic [31:0] io_req_wdata;
  logic [3:0]  io_req_wstrb;
  logic        io_resp_valid;
  logic [31:0] io_resp_rdata;
  logic        io_resp_err;
  logic [7:0]  io_axi_ar_id;
  logic [31:0] io_axi_ar_addr;
  logic [7:0]  io_axi_ar_len;
  logic [2:0]  io_axi_ar_size;
  logic [1:0]  io_axi_ar_burst;
  logic        io_axi_ar_valid;
  logic        io_axi_ar_ready;
  logic [7:0]  io_axi_r_id;
  logic [1:0]  io_axi_r_resp;
  logic [31:0] io_axi_r_data;
  logic        io_axi_r_last;
  logic        io_axi_r_valid;
  logic        io_axi_r_ready;
  logic [7:0]  io_axi_aw_id;
  logic [31:0] io_axi_aw_addr;
  logic [7:0]  io_axi_aw_len;
  logic [2:0]  io_axi_aw_size;
  logic [1:0]  io_axi_aw_burst;
  logic        io_axi_aw_valid;
  logic        io_axi_aw_ready;
  logic [31:0] io_axi_w_data;
  logic [3:0]  io_axi_w_strb;
  logic        io_axi_w_last;
  logic        io_axi_w_valid;
  logic        io_axi_w_ready;
  logic [7:0]  io_axi_b_id;
  logic [1:0]  io_axi_b_resp;
  logic        io_axi_b_valid;
  logic        io_axi_b_ready;

  int total_cnt;
  int bad_cnt;

  // handshake monitors
  int          ar_hs_cnt;
  int          aw_hs_cnt;
  int          w_hs_cnt;
  int          b_hs_cnt;
  int          resp_cnt;
  logic [31:0] aw_addr_seen;
  logic [31:0] w_data_seen;
  logic [3:0]  w_strb_seen;
  logic        w_last_seen;

  mmio_axi_master dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .io_req_valid    (io_req_valid),
    .io_req_ready    (io_req_ready),
    .io_req_we       (io_req_we),
    .io_req_addr     (io_req_addr),
    .io_req_wdata    (io_req_wdata),
    .io_req_wstrb    (io_req_wstrb),
    .io_resp_valid   (io_resp_valid),
    .io_resp_rdata   (io_resp_rdata),
    .io_resp_err     (io_resp_err),
    .io_axi_ar_id    (io_axi_ar_id),
    .io_axi_ar_addr  (io_axi_ar_addr),
    .io_axi_ar_len   (io_axi_ar_len),
    .io_axi_ar_size  (io_axi_ar_size),
    .io_axi_ar_burst (io_axi_ar_burst),
    .io_axi_ar_valid (io_axi_ar_valid),
    .io_axi_ar_ready (io_axi_ar_ready),
    .io_axi_r_id     (io_axi_r_id),
    .io_axi_r_resp   (io_axi_r_resp),
    .io_axi_r_data   (io_axi_r_data),
    .io_axi_r_last   (io_axi_r_last),
    .io_axi_r_valid  (io_axi_r_valid),
    .io_axi_r_ready  (io_axi_r_ready),
    .io_axi_aw_id    (io_axi_aw_id),
    .io_axi_aw_addr  (io_axi_aw_addr),
    .io_axi_aw_len   (io_axi_aw_len),
    .io_axi_aw_size  (io_axi_aw_size),
    .io_axi_aw_burst (io_axi_aw_burst),
    .io_axi_aw_valid (io_axi_aw_valid),
    .io_axi_aw_ready (io_axi_aw_ready),
    .io_axi_w_data   (io_axi_w_data),
    .io_axi_w_strb   (io_axi_w_strb),
    .io_axi_w_last   (io_axi_w_last),
    .io_axi_w_valid  (io_axi_w_valid),
    .io_axi_w_ready  (io_axi_w_ready),
    .io_axi_b_id     (io_axi_b_id),
    .io_axi_b_resp   (io_axi_b_resp),
    .io_axi_b_valid  (io_axi_b_valid),
    .io_axi_b_ready  (io_axi_b_ready)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshakes and capture write-channel payload at the handshake edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_hs_cnt <= 0;
      aw_hs_cnt <= 0;
      w_hs_cnt  <= 0;
      b_hs_cnt  <= 0;
      resp_cnt  <= 0;
    end else begin
      if (io_axi_ar_valid && io_axi_ar_ready) ar_hs_cnt <= ar_hs_cnt + 1;
      if (io_axi_aw_valid && io_axi_aw_ready) begin
        aw_hs_cnt    <= aw_hs_cnt + 1;
        aw_addr_seen <= io_axi_aw_addr;
      end
      if (io_axi_w_valid && io_axi_w_ready) begin
        w_hs_cnt    <= w_hs_cnt + 1;
        w_data_seen <= io_axi_w_data;
        w_strb_seen <= io_axi_w_strb;
        w_last_seen <= io_axi_w_last;
      end
      if (io_axi_b_valid && io_axi_b_ready) b_hs_cnt <= b_hs_cnt + 1;
      if (io_resp_valid) resp_cnt <= resp_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; the block is idle so it is taken at the next edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    chk("req_ready_idle", {63'd0, io_req_ready}, 64'd1);
    io_req_valid = 1'b1;
    io_req_we    = we;
    io_req_addr  = addr;
    io_req_wdata = wdata;
    io_req_wstrb = wstrb;
    tick();
    io_req_valid = 1'b0;
    chk("req_ready_busy", {63'd0, io_req_ready}, 64'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_delay, input logic [31:0] data,
                         input logic [1:0] resp, input logic [7:0] rid, input logic rlast,
                         input logic exp_err);
    int ar0, r0;
    int n;
    ar0 = ar_hs_cnt;
    r0  = resp_cnt;
    issue(1'b0, addr, 32'h0, 4'h0);
    for (int i = 0; i < ar_delay; i++) begin
      chk("ar_valid_hold", {63'd0, io_axi_ar_valid}, 64'd1);
      chk("ar_addr_hold", {32'd0, io_axi_ar_addr}, {32'd0, addr});
      chk("req_ready_hold", {63'd0, io_req_ready}, 64'd0);
      tick();
    end
    chk("ar_addr", {32'd0, io_axi_ar_addr}, {32'd0, addr});
    chk("ar_fields", {38'd0, io_axi_ar_id, io_axi_ar_len, io_axi_ar_size, io_axi_ar_burst},
        {38'd0, 8'h00, 8'h00, 3'b010, 2'b01});
    io_axi_ar_ready = 1'b1;
    n = 0;
    while (!io_axi_ar_valid && n < 20) begin
      tick();
      n++;
    end
    chk("ar_timeout", {63'd0, io_axi_ar_valid}, 64'd1);
    tick();
    io_axi_ar_ready = 1'b0;
    chk("r_ready", {63'd0, io_axi_r_ready}, 64'd1);
    io_axi_r_valid = 1'b1;
    io_axi_r_data  = data;
    io_axi_r_resp  = resp;
    io_axi_r_id    = rid;
    io_axi_r_last  = rlast;
    tick();
    io_axi_r_valid = 1'b0;
    chk("rd_resp_valid", {63'd0, io_resp_valid}, 64'd1);
    chk("rd_rdata", {32'd0, io_resp_rdata}, {32'd0, data});
    chk("rd_err", {63'd0, io_resp_err}, {63'd0, exp_err});
    tick();
    chk("rd_resp_pulse", {63'd0, io_resp_valid}, 64'd0);
    chk("rd_err_held", {63'd0, io_resp_err}, {63'd0, exp_err});
    chk("ar_hs_once", 64'(ar_hs_cnt - ar0), 64'd1);
    chk("rd_resp_once", 64'(resp_cnt - r0), 64'd1);
  endtask

  // Each ready is raised for exactly one cycle at its chosen offset from the start of WR_AW_W.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int w_delay, input logic [7:0] bid,
                          input logic [1:0] bresp, input logic exp_err, input logic finish_b);
    int aw0, w0, b0, r0, n, last;
    aw0 = aw_hs_cnt;
    w0  = w_hs_cnt;
    b0  = b_hs_cnt;
    r0  = resp_cnt;
    issue(1'b1, addr, data, strb);
    chk("aw_w_valid_together", {62'd0, io_axi_aw_valid, io_axi_w_valid}, 64'd3);
    last = (aw_delay > w_delay) ? aw_delay : w_delay;
    for (int k = 0; k <= last; k++) begin
      io_axi_aw_ready = (k == aw_delay);
      io_axi_w_ready  = (k == w_delay);
      tick();
    end
    io_axi_aw_ready = 1'b0;
    io_axi_w_ready  = 1'b0;
    chk("aw_hs_once", 64'(aw_hs_cnt - aw0), 64'd1);
    chk("w_hs_once", 64'(w_hs_cnt - w0), 64'd1);
    chk("aw_addr", {32'd0, aw_addr_seen}, {32'd0, addr});
    chk("w_data", {32'd0, w_data_seen}, {32'd0, data});
    chk("w_strb_last", {59'd0, w_strb_seen, w_last_seen}, {59'd0, strb, 1'b1});
    n = 0;
    while (!io_axi_b_ready && n < 20) begin
      tick();
      n++;
    end
    chk("b_ready", {63'd0, io_axi_b_ready}, 64'd1);
    if (finish_b) begin
      chk("no_resp_before_b", {63'd0, io_resp_valid}, 64'd0);
      io_axi_b_valid = 1'b1;
      io_axi_b_id    = bid;
      io_axi_b_resp  = bresp;
      tick();
      io_axi_b_valid = 1'b0;
      chk("wr_resp_valid", {63'd0, io_resp_valid}, 64'd1);
      chk("wr_rdata_zero", {32'd0, io_resp_rdata}, 64'd0);
      chk("wr_err", {63'd0, io_resp_err}, {63'd0, exp_err});
      tick();
      chk("wr_resp_pulse", {63'd0, io_resp_valid}, 64'd0);
      chk("b_hs_once", 64'(b_hs_cnt - b0), 64'd1);
      chk("wr_resp_once", 64'(resp_cnt - r0), 64'd1);
    end
  endtask

  initial begin
    total_cnt       = 0;
    bad_cnt         = 0;
    rst_n           = 1'b0;
    io_req_valid    = 1'b0;
    io_req_we       = 1'b0;
    io_req_addr     = 32'h0;
    io_req_wdata    = 32'h0;
    io_req_wstrb    = 4'h0;
    io_axi_ar_ready = 1'b0;
    io_axi_r_id     = 8'h00;
    io_axi_r_resp   = 2'b00;
    io_axi_r_data   = 32'h0;
    io_axi_r_last   = 1'b1;
    io_axi_r_valid  = 1'b0;
    io_axi_aw_ready = 1'b0;
    io_axi_w_ready  = 1'b0;
    io_axi_b_id     = 8'h00;
    io_axi_b_resp   = 2'b00;
    io_axi_b_valid  = 1'b0;
    tick();
    tick();
    // reset values
    chk("rst_req_ready", {63'd0, io_req_ready}, 64'd1);
    chk("rst_valids", {58'd0, io_resp_valid, io_axi_ar_valid, io_axi_r_ready,
                       io_axi_aw_valid, io_axi_w_valid, io_axi_b_ready}, 64'd0);
    chk("rst_data", {io_axi_ar_addr, io_resp_rdata}, 64'd0);
    chk("rst_wdata", {io_axi_aw_addr, io_axi_w_data}, 64'd0);
    rst_n = 1'b1;
    tick();

    // UART load, immediate responder
    do_read(32'hBFD0_03F8, 0, 32'h0000_0041, 2'b00, 8'h00, 1'b1, 1'b0);
    // UART store, w_ready 3 cycles after aw_ready
    do_write(32'hBFD0_03F8, 32'h0000_0055, 4'b0001, 0, 3, 8'h00, 2'b00, 1'b0, 1'b1);
    // W before AW
    do_write(32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, 2, 0, 8'h00, 2'b00, 1'b0, 1'b1);
    // AW and W in the same cycle
    do_write(32'h1000_0008, 32'h1234_5678, 4'b0110, 1, 1, 8'h00, 2'b00, 1'b0, 1'b1);
    // SLVERR read, then a normal read is accepted
    do_read(32'h2000_0000, 0, 32'hCAFE_0001, 2'b10, 8'h00, 1'b1, 1'b1);
    do_read(32'h2000_0004, 0, 32'h0000_00A5, 2'b00, 8'h00, 1'b1, 1'b0);
    // r_last missing and wrong r_id are errors
    do_read(32'h2000_0008, 0, 32'h0000_0001, 2'b00, 8'h00, 1'b0, 1'b1);
    do_read(32'h2000_000C, 0, 32'h0000_0002, 2'b00, 8'h07, 1'b1, 1'b1);
    // wrong b_id and DECERR on writes
    do_write(32'h3000_0000, 32'h0000_0001, 4'b0001, 0, 0, 8'h01, 2'b00, 1'b1, 1'b1);
    do_write(32'h3000_0004, 32'h0000_0002, 4'b0011, 0, 0, 8'h00, 2'b11, 1'b1, 1'b1);
    // ar_ready stalled 10 cycles
    do_read(32'hBFD0_03FC, 10, 32'h7777_0000, 2'b00, 8'h00, 1'b1, 1'b0);

    // reset while waiting in WR_B
    do_write(32'h4000_0000, 32'h0000_00FF, 4'b1111, 0, 0, 8'h00, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valids", {58'd0, io_resp_valid, io_axi_ar_valid, io_axi_r_ready,
                           io_axi_aw_valid, io_axi_w_valid, io_axi_b_ready}, 64'd0);
    chk("mid_rst_req_ready", {63'd0, io_req_ready}, 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {62'd0, io_req_ready, io_axi_b_ready}, 64'd2);
    do_read(32'hBFD0_03F8, 0, 32'h0000_0042, 2'b00, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
